// File: rtl/joypad_port_responder_pkg.sv
// rtl/joypad_port_responder_pkg.sv - shared types, pad word packing and FSM encoding for the joypad port responder
package joypad_port_responder_pkg;

    localparam logic [3:0] PAD_ID = 4'hF;

    typedef logic [31:0] pad_word_t;

    // One controller as delivered by the HMI path; buttons are active high.
    typedef struct packed {
        logic [6:1] b;
        logic       select;
        logic       run;
        logic       u;
        logic       d;
        logic       l;
        logic       r;
        logic       mode1;
        logic       mode2;
    } joypad_t;

    typedef struct packed {
        joypad_t jp1;
        joypad_t jp2;
    } hmi_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } pad_state_e;

    // Build the 32-bit word returned to the console; an absent pad reads as all zero (ID 0).
    function automatic pad_word_t pad_pack(input joypad_t jp, input logic connected);
        pad_word_t w;
        w = '0;
        if (connected) begin
            w[5:0]   = jp.b;
            w[6]     = jp.select;
            w[7]     = jp.run;
            w[8]     = jp.u;
            w[9]     = jp.r;
            w[10]    = jp.d;
            w[11]    = jp.l;
            w[12]    = jp.mode1;
            w[14]    = jp.mode2;
            w[31:28] = PAD_ID;
        end
        return w;
    endfunction

endpackage

// File: rtl/joypad_port_responder_if.sv
// rtl/joypad_port_responder_if.sv - console-side pad port signals with console and pad modports
interface joypad_port_responder_if;
    logic pad_latch;
    logic pad_clk;
    logic pad_dout;
    logic busy;

    modport master (output pad_latch, output pad_clk, input pad_dout, input busy);
    modport slave  (input pad_latch, input pad_clk, output pad_dout, output busy);
endinterface

// File: rtl/joypad_port_responder_sync_edge.sv
// rtl/joypad_port_responder_sync_edge.sv - multi-flop synchronizer with registered rise/fall pulses
module joypad_port_responder_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchronize the console line, then register edge pulses; prev_q is the level aligned with the pulses.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/joypad_port_responder.sv
// rtl/joypad_port_responder.sv - pad-side joypad port: latch capture and LSB-first serial word output
module joypad_port_responder
    import joypad_port_responder_pkg::*;
#(
    parameter int PORT        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    CLK,
    input  logic                    RESn,
    input  hmi_t                    hmi,
    input  logic                    connected,
    joypad_port_responder_if.slave  port
);
    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    logic latch_lvl, latch_rise, latch_fall;
    logic clk_lvl, clk_rise, clk_fall;
    logic unused_sync;

    pad_state_e      state_q, state_d;
    pad_word_t       shreg_q, shreg_d;
    logic [4:0]      bitcnt_q, bitcnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pad_dout_q, pad_dout_d;
    logic            busy_q, busy_d;
    joypad_t         jp_sel;

    joypad_port_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk_i    (CLK),
        .resetn_i (RESn),
        .async_i  (port.pad_latch),
        .level_o  (latch_lvl),
        .rise_o   (latch_rise),
        .fall_o   (latch_fall)
    );

    joypad_port_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_i    (CLK),
        .resetn_i (RESn),
        .async_i  (port.pad_clk),
        .level_o  (clk_lvl),
        .rise_o   (clk_rise),
        .fall_o   (clk_fall)
    );

    assign unused_sync = ^{latch_fall, clk_lvl, clk_rise};
    assign jp_sel      = (PORT == 1) ? hmi.jp2 : hmi.jp1;

    // Next-state logic: latch_rise always wins over a coincident clock fall.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (latch_rise) begin
                    shreg_d  = pad_pack(jp_sel, connected);
                    bitcnt_d = 5'd0;
                    timer_d  = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (latch_rise) begin
                    shreg_d  = pad_pack(jp_sel, connected);
                    bitcnt_d = 5'd0;
                    timer_d  = '0;
                end else if (clk_fall && !latch_lvl) begin
                    shreg_d = shreg_q >> 1;
                    timer_d = '0;
                    if (bitcnt_q == 5'd31) begin
                        state_d = ST_DONE;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_IDLE;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d     = (state_d == ST_SHIFT);
        pad_dout_d = (state_d == ST_SHIFT) ? shreg_d[0] : 1'b0;
    end

    // State, shift register and registered outputs; reset drops any partial word.
    always_ff @(posedge CLK) begin
        if (!RESn) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= 5'd0;
            timer_q    <= '0;
            pad_dout_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            timer_q    <= timer_d;
            pad_dout_q <= pad_dout_d;
            busy_q     <= busy_d;
        end
    end

    assign port.pad_dout = pad_dout_q;
    assign port.busy     = busy_q;

endmodule

// File: tb/tb_joypad_port_responder.sv
// tb/tb_joypad_port_responder.sv - scoreboard bench for the joypad port responder
module tb_joypad_port_responder;
    import joypad_port_responder_pkg::*;

    logic CLK;
    logic RESn;
    hmi_t hmi;
    logic connected;
    logic pad_latch;
    logic pad_clk;

    int n_checks;
    int n_fail;

    logic [2:0]  dout_v;
    logic [2:0]  busy_v;
    logic [31:0] exp_q [3][$];
    logic [31:0] got [3];
    int          nb [3];

    joypad_port_responder_if if0 ();
    joypad_port_responder_if if1 ();
    joypad_port_responder_if if2 ();

    assign if0.pad_latch = pad_latch;
    assign if0.pad_clk   = pad_clk;
    assign if1.pad_latch = pad_latch;
    assign if1.pad_clk   = pad_clk;
    assign if2.pad_latch = pad_latch;
    assign if2.pad_clk   = pad_clk;
    assign dout_v = {if2.pad_dout, if1.pad_dout, if0.pad_dout};
    assign busy_v = {if2.busy, if1.busy, if0.busy};

    joypad_port_responder #(.PORT(0)) dut0 (
        .CLK(CLK), .RESn(RESn), .hmi(hmi), .connected(connected), .port(if0.slave));
    joypad_port_responder #(.PORT(1)) dut1 (
        .CLK(CLK), .RESn(RESn), .hmi(hmi), .connected(connected), .port(if1.slave));
    joypad_port_responder #(.PORT(0), .TIMEOUT_CYC(16)) dut2 (
        .CLK(CLK), .RESn(RESn), .hmi(hmi), .connected(connected), .port(if2.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected pad word derived from the button-to-bit table with plain arithmetic.
    function automatic logic [31:0] model(input joypad_t j, input bit conn);
        logic [31:0] w;
        if (!conn) return 32'h0;
        w = 32'hF000_0000;
        for (int i = 1; i <= 6; i++) if (j.b[i]) w = w + (32'd1 << (i - 1));
        if (j.select) w = w + 32'd64;
        if (j.run)    w = w + 32'd128;
        if (j.u)      w = w + 32'd256;
        if (j.r)      w = w + 32'd512;
        if (j.d)      w = w + 32'd1024;
        if (j.l)      w = w + 32'd2048;
        if (j.mode1)  w = w + 32'd4096;
        if (j.mode2)  w = w + 32'd16384;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic word_done(input int k);
        logic [31:0] e;
        if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected_word_dut%0d", k), got[k], 32'hxxxx_xxxx);
        end else begin
            e = exp_q[k].pop_front();
            check($sformatf("word_dut%0d", k), got[k], e);
        end
    endtask

    // Monitor: a console-style receiver sampling each pad just before every clock fall.
    initial for (int k = 0; k < 3; k++) nb[k] = 99;

    always @(posedge pad_latch) begin
        for (int k = 0; k < 3; k++) nb[k] = 0;
    end

    always @(negedge pad_clk) begin
        if (!pad_latch) begin
            for (int k = 0; k < 3; k++) begin
                if (nb[k] < 32) begin
                    if (!busy_v[k]) begin
                        nb[k] = 99;
                    end else begin
                        got[k][nb[k]] = dout_v[k];
                        nb[k] = nb[k] + 1;
                        if (nb[k] == 32) word_done(k);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic latch_pulse();
        pad_latch = 1'b1;
        wait_clk(6);
        pad_latch = 1'b0;
        wait_clk(6);
    endtask

    task automatic falls(input int n);
        for (int i = 0; i < n; i++) begin
            pad_clk = 1'b0;
            wait_clk(6);
            pad_clk = 1'b1;
            wait_clk(6);
        end
    endtask

    task automatic push_expected(input bit use2);
        exp_q[0].push_back(model(hmi.jp1, connected));
        exp_q[1].push_back(model(hmi.jp2, connected));
        if (use2) exp_q[2].push_back(model(hmi.jp1, connected));
    endtask

    task automatic do_read(input bit use2);
        push_expected(use2);
        latch_pulse();
        falls(32);
        check("dout_after_word_dut0", {31'd0, dout_v[0]}, 32'd0);
        check("busy_after_word_dut0", {31'd0, busy_v[0]}, 32'd0);
        check("busy_after_word_dut1", {31'd0, busy_v[1]}, 32'd0);
    endtask

    task automatic random_hmi();
        logic [27:0] r;
        r = 28'($urandom);
        hmi = r;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        RESn      = 1'b0;
        pad_latch = 1'b0;
        pad_clk   = 1'b1;
        hmi       = '0;
        connected = 1'b1;
        wait_clk(3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_dout_dut%0d", k), {31'd0, dout_v[k]}, 32'd0);
            check($sformatf("reset_busy_dut%0d", k), {31'd0, busy_v[k]}, 32'd0);
        end
        RESn = 1'b1;
        wait_clk(4);

        // Directed words: b1 on pad 1, left on pad 2.
        hmi = '0;
        hmi.jp1.b[1] = 1'b1;
        hmi.jp2.l    = 1'b1;
        do_read(1'b1);

        hmi = '0;
        hmi.jp1.select = 1'b1;
        hmi.jp1.run    = 1'b1;
        hmi.jp1.u      = 1'b1;
        do_read(1'b1);

        connected = 1'b0;
        random_hmi();
        do_read(1'b1);
        connected = 1'b1;

        for (int i = 0; i < 8; i++) begin
            random_hmi();
            connected = ($urandom_range(0, 3) != 0);
            do_read(1'b1);
        end
        connected = 1'b1;

        // Re-latch after 10 falls with new button state.
        random_hmi();
        latch_pulse();
        falls(10);
        random_hmi();
        do_read(1'b1);

        // Latch rise coincident with a clock fall, then falls while latch is held high.
        random_hmi();
        hmi.jp1.b[1] = 1'b1;
        hmi.jp1.b[2] = 1'b0;
        push_expected(1'b0);
        pad_latch = 1'b1;
        pad_clk   = 1'b0;
        wait_clk(6);
        pad_clk = 1'b1;
        wait_clk(6);
        pad_clk = 1'b0;
        wait_clk(6);
        pad_clk = 1'b1;
        wait_clk(6);
        pad_latch = 1'b0;
        wait_clk(6);
        check("bit0_after_ignored_falls", {31'd0, dout_v[0]}, 32'd1);
        falls(32);

        // Timeout on the short-timeout instance only.
        random_hmi();
        latch_pulse();
        falls(3);
        wait_clk(16);
        check("timeout_busy_dut2", {31'd0, busy_v[2]}, 32'd0);
        check("timeout_dout_dut2", {31'd0, dout_v[2]}, 32'd0);
        check("no_timeout_busy_dut0", {31'd0, busy_v[0]}, 32'd1);
        random_hmi();
        do_read(1'b1);

        // Reset mid-word.
        random_hmi();
        latch_pulse();
        falls(6);
        RESn = 1'b0;
        wait_clk(1);
        RESn = 1'b1;
        check("midreset_dout_dut0", {31'd0, dout_v[0]}, 32'd0);
        check("midreset_busy_dut0", {31'd0, busy_v[0]}, 32'd0);
        wait_clk(4);
        for (int i = 0; i < 5; i++) begin
            pad_clk = 1'b0;
            wait_clk(6);
            check("post_reset_dout_dut0", {31'd0, dout_v[0]}, 32'd0);
            check("post_reset_busy_dut1", {31'd0, busy_v[1]}, 32'd0);
            pad_clk = 1'b1;
            wait_clk(6);
        end
        random_hmi();
        do_read(1'b1);

        for (int k = 0; k < 3; k++)
            check($sformatf("words_outstanding_dut%0d", k), exp_q[k].size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
